detect_sequencer: RTL

Frame sequencer for the five-state one-hot pair detector (w/z, hit when the last two serial bits are equal). Accepts a parallel WIDTH-bit frame on a start pulse, clears the detector, shifts the frame into it MSB first, counts detector hits, and reports the count with a one-cycle done pulse. Sits between a parallel source (switches/register) and the serial detector; display logic reads `hit_count`.

---
 rtl/detect_sequencer_pkg.sv | 17 +
 rtl/detect_sequencer_if.sv | 13 +
 rtl/detect_sequencer_pair_detector.sv | 20 ++
 rtl/detect_sequencer.sv | 62 ++++++
 4 files changed

// File: rtl/detect_sequencer_pkg.sv
// detseq_pkg: one-hot state indices, state encoding and default frame width for detect_sequencer
package detseq_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int NSTATES = 5;
    localparam int IDLE = 0;
    localparam int CLEAR = 1;
    localparam int SHIFT = 2;
    localparam int FLUSH = 3;
    localparam int DONE = 4;
    typedef enum logic [NSTATES-1:0] {
        S_IDLE  = 5'b00001,
        S_CLEAR = 5'b00010,
        S_SHIFT = 5'b00100,
        S_FLUSH = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;
endpackage

// File: rtl/detect_sequencer_if.sv
// detect_sequencer_if: frame request/result bundle
// master (source): drives start, data; reads busy, done, bit_out, hit_count
// slave (sequencer): the reverse
interface detect_sequencer_if import detseq_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic start;
    logic [WIDTH-1:0] data;
    logic busy;
    logic done;
    logic bit_out;
    logic [$clog2(WIDTH)-1:0] hit_count;
    modport master (output start, data, input busy, done, bit_out, hit_count);
    modport slave (input start, data, output busy, done, bit_out, hit_count);
endinterface

// File: rtl/detect_sequencer_pair_detector.sv
// pair_detector: five-state one-hot Moore detector, z=1 once the last two bits of w are equal
// ports: clock, reset (sync, active-high, returns to initial state), w (serial in), z (registered hit)
module pair_detector (
    input  logic clock,
    input  logic reset,
    input  logic w,
    output logic z
);
    // y[0]=initial, y[1]=one 0, y[2]=run of 0s, y[3]=one 1, y[4]=run of 1s
    logic [4:0] y, y_n;
    always_comb begin
        y_n[0] = 1'b0;
        y_n[1] = ~w & (y[0] | y[3] | y[4]);
        y_n[2] = ~w & (y[1] | y[2]);
        y_n[3] = w & (y[0] | y[1] | y[2]);
        y_n[4] = w & (y[3] | y[4]);
    end
    always_ff @(posedge clock) y <= reset ? 5'b00001 : y_n;
    assign z = y[2] | y[4];
endmodule

// File: rtl/detect_sequencer.sv
// detect_sequencer: shifts a latched frame MSB first through pair_detector and counts hits
// ports: clock, reset (sync, active-high), bus (detect_sequencer_if.slave: start, data, busy, done, bit_out, hit_count)
// DETSEQ_BACK2BACK_EN: when defined, start is also accepted in DONE for a WIDTH+3 frame period
module detect_sequencer import detseq_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clock,
    input  logic reset,
    detect_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    state_t state, state_n;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0] cnt, hits;
    logic z, accept, last;
`ifdef DETSEQ_BACK2BACK_EN
    assign accept = bus.start & (state[IDLE] | state[DONE]);
`else
    assign accept = bus.start & state[IDLE];
`endif
    assign last = cnt == CW'(WIDTH - 1);
    always_ff @(posedge clock) state <= reset ? S_IDLE : state_n;
    always_comb begin
        state_n = S_IDLE;
        case (state)
            S_IDLE:  state_n = accept ? S_CLEAR : S_IDLE;
            S_CLEAR: state_n = S_SHIFT;
            S_SHIFT: state_n = last ? S_FLUSH : S_SHIFT;
            S_FLUSH: state_n = S_DONE;
            S_DONE:  state_n = accept ? S_CLEAR : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            sr <= '0;
            cnt <= '0;
            hits <= '0;
        end else begin
            if (accept) begin
                sr <= bus.data;
                cnt <= '0;
                hits <= '0;
            end else if (state[SHIFT]) begin
                sr <= {sr[WIDTH-2:0], 1'b0};
                cnt <= cnt + 1'b1;
            end
            // z lags w by one cycle, so FLUSH picks up the final bit's result
            if ((state[SHIFT] | state[FLUSH]) & z) hits <= hits + 1'b1;
        end
    end
    pair_detector u_det (
        .clock(clock),
        .reset(reset | state[CLEAR]),
        .w(bus.bit_out),
        .z(z)
    );
    assign bus.busy = state[CLEAR] | state[SHIFT] | state[FLUSH];
    assign bus.done = state[DONE];
    assign bus.bit_out = state[SHIFT] & sr[WIDTH-1];
    assign bus.hit_count = hits;
endmodule
